// File: rtl/vai_mmio_initiator_if.sv
// vai_mmio_initiator_if: bundles the command, MMIO request, c2 response and
// result signals of the MMIO initiator.
//   master  - the initiator's view (drives cmd_ready, mmio_*, rsp_*, stray_rsp)
//   slave   - the command/fabric side (drives cmd_*, c2_rsp_*, rsp_ready)
// Parameter TID_WIDTH sets the width of mmio_tid and c2_rsp_tid.
interface vai_mmio_initiator_if #(
    parameter int unsigned TID_WIDTH = 9
) ();
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_write;
    logic [15:0]          cmd_addr;
    logic [63:0]          cmd_data;

    logic                 mmio_rd_valid;
    logic                 mmio_wr_valid;
    logic [15:0]          mmio_addr;
    logic [TID_WIDTH-1:0] mmio_tid;
    logic [63:0]          mmio_wdata;

    logic                 c2_rsp_valid;
    logic [TID_WIDTH-1:0] c2_rsp_tid;
    logic [63:0]          c2_rsp_data;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [63:0]          rsp_data;
    logic                 rsp_timeout;
    logic                 stray_rsp;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_data,
        input  c2_rsp_valid, c2_rsp_tid, c2_rsp_data,
        input  rsp_ready,
        output cmd_ready,
        output mmio_rd_valid, mmio_wr_valid, mmio_addr, mmio_tid, mmio_wdata,
        output rsp_valid, rsp_data, rsp_timeout, stray_rsp
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_data,
        output c2_rsp_valid, c2_rsp_tid, c2_rsp_data,
        output rsp_ready,
        input  cmd_ready,
        input  mmio_rd_valid, mmio_wr_valid, mmio_addr, mmio_tid, mmio_wdata,
        input  rsp_valid, rsp_data, rsp_timeout, stray_rsp
    );
endinterface

// File: rtl/vai_mmio_initiator.sv
// vai_mmio_initiator: requesting end of the CCI-P MMIO protocol. Turns simple
// read/write commands into one-cycle MMIO request strobes, matches the c2 read
// response by tid and returns the data (or a timeout error) to the command side.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   bus        - vai_mmio_initiator_if.master (command, MMIO request, c2 response,
//                result and stray_rsp signals)
// Optional feature: define VAI_MMIO_INIT_TIMEOUT_EN to enable the read timeout timer;
// without it a read waits indefinitely for its tid and rsp_timeout is tied 0.
module vai_mmio_initiator #(
    parameter int unsigned TID_WIDTH      = 9,
    parameter int unsigned TIMEOUT_CYCLES = 512
) (
    input logic                     clk,
    input logic                     reset,
    vai_mmio_initiator_if.master    bus
);
    typedef enum logic [1:0] {StIdle, StRdWait, StRspHold} state_t;

    state_t               state_q, state_d;
    logic [TID_WIDTH-1:0] tid_q, tid_d;
    logic [TID_WIDTH-1:0] exp_tid_q, exp_tid_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 wr_valid_q, wr_valid_d;
    logic [15:0]          addr_q, addr_d;
    logic [TID_WIDTH-1:0] req_tid_q, req_tid_d;
    logic [63:0]          wdata_q, wdata_d;
    logic [63:0]          rsp_data_q, rsp_data_d;
    logic                 stray_q, stray_d;
    logic                 rsp_match;
    logic                 unused_addr_lsb;

`ifdef VAI_MMIO_INIT_TIMEOUT_EN
    localparam int unsigned TimerW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              rsp_to_q, rsp_to_d;
`else
    localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
`endif

    assign unused_addr_lsb = bus.cmd_addr[0];
    assign rsp_match = bus.c2_rsp_valid && (bus.c2_rsp_tid == exp_tid_q);

    always_comb begin
        state_d    = state_q;
        tid_d      = tid_q;
        exp_tid_d  = exp_tid_q;
        rd_valid_d = 1'b0;
        wr_valid_d = 1'b0;
        addr_d     = '0;
        req_tid_d  = '0;
        wdata_d    = '0;
        rsp_data_d = rsp_data_q;
        stray_d    = 1'b0;
`ifdef VAI_MMIO_INIT_TIMEOUT_EN
        timer_d    = timer_q;
        rsp_to_d   = rsp_to_q;
`endif
        case (state_q)
            StIdle: begin
                stray_d = bus.c2_rsp_valid;
                if (bus.cmd_valid) begin
                    addr_d    = {bus.cmd_addr[15:1], 1'b0};
                    req_tid_d = tid_q;
                    tid_d     = tid_q + TID_WIDTH'(1);
                    if (bus.cmd_write) begin
                        wr_valid_d = 1'b1;
                        wdata_d    = bus.cmd_data;
                    end else begin
                        rd_valid_d = 1'b1;
                        exp_tid_d  = tid_q;
                        state_d    = StRdWait;
`ifdef VAI_MMIO_INIT_TIMEOUT_EN
                        timer_d    = '0;
`endif
                    end
                end
            end
            StRdWait: begin
                // A match takes priority over a coincident timer expiry.
                if (rsp_match) begin
                    rsp_data_d = bus.c2_rsp_data;
                    state_d    = StRspHold;
`ifdef VAI_MMIO_INIT_TIMEOUT_EN
                    rsp_to_d   = 1'b0;
`endif
                end else begin
                    stray_d = bus.c2_rsp_valid;
`ifdef VAI_MMIO_INIT_TIMEOUT_EN
                    if (timer_q == TimerW'(TIMEOUT_CYCLES - 1)) begin
                        rsp_data_d = '1;
                        rsp_to_d   = 1'b1;
                        state_d    = StRspHold;
                    end else if (!bus.c2_rsp_valid) begin
                        // A stray response neither resets nor advances the timer.
                        timer_d = timer_q + TimerW'(1);
                    end
`endif
                end
            end
            StRspHold: begin
                stray_d = bus.c2_rsp_valid;
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            tid_q      <= '0;
            exp_tid_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_valid_q <= 1'b0;
            addr_q     <= '0;
            req_tid_q  <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
            stray_q    <= 1'b0;
`ifdef VAI_MMIO_INIT_TIMEOUT_EN
            timer_q    <= '0;
            rsp_to_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tid_q      <= tid_d;
            exp_tid_q  <= exp_tid_d;
            rd_valid_q <= rd_valid_d;
            wr_valid_q <= wr_valid_d;
            addr_q     <= addr_d;
            req_tid_q  <= req_tid_d;
            wdata_q    <= wdata_d;
            rsp_data_q <= rsp_data_d;
            stray_q    <= stray_d;
`ifdef VAI_MMIO_INIT_TIMEOUT_EN
            timer_q    <= timer_d;
            rsp_to_q   <= rsp_to_d;
`endif
        end
    end

    assign bus.cmd_ready     = (state_q == StIdle);
    assign bus.mmio_rd_valid = rd_valid_q;
    assign bus.mmio_wr_valid = wr_valid_q;
    assign bus.mmio_addr     = addr_q;
    assign bus.mmio_tid      = req_tid_q;
    assign bus.mmio_wdata    = wdata_q;
    assign bus.rsp_valid     = (state_q == StRspHold);
    assign bus.rsp_data      = rsp_data_q;
    assign bus.stray_rsp     = stray_q;
`ifdef VAI_MMIO_INIT_TIMEOUT_EN
    assign bus.rsp_timeout   = rsp_to_q;
`else
    assign bus.rsp_timeout   = 1'b0;
`endif
endmodule

// File: tb/tb_vai_mmio_initiator.sv
// Scoreboard bench for vai_mmio_initiator: stimulus pushes expected requests,
// responses and stray pulses into queues; a negedge monitor pops and compares.
module tb_vai_mmio_initiator;
    localparam int unsigned TW = 9;
    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vai_mmio_initiator_if #(.TID_WIDTH(TW)) bus ();

    vai_mmio_initiator #(
        .TID_WIDTH      (TW),
        .TIMEOUT_CYCLES (TO)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic          rd;
        logic [15:0]   addr;
        logic [TW-1:0] tid;
        logic [63:0]   wdata;
        int            cyc;
    } req_t;

    typedef struct {
        logic [63:0] data;
        logic        to;
        int          cyc;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    int   stray_q[$];

    int unsigned   total = 0;
    int unsigned   bad = 0;
    int            cyc = 0;
    logic [TW-1:0] tid_model = '0;
    logic          rsp_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        total++;
        bad++;
        $display("FAIL %s: output with nothing expected (cycle %0d)", name, cyc);
    endtask

    // Monitor: compares every DUT output event against the scoreboard queues.
    always @(negedge clk) begin
        req_t e;
        rsp_t r;
        if (bus.mmio_rd_valid || bus.mmio_wr_valid) begin
            if (req_q.size() == 0) begin
                unexpected("mmio_req");
            end else begin
                e = req_q.pop_front();
                check("req_cycle", 64'(cyc), 64'(e.cyc));
                check("req_rd", {63'd0, bus.mmio_rd_valid}, {63'd0, e.rd});
                check("req_wr", {63'd0, bus.mmio_wr_valid}, {63'd0, !e.rd});
                check("req_addr", {48'd0, bus.mmio_addr}, {48'd0, e.addr});
                check("req_tid", 64'(bus.mmio_tid), 64'(e.tid));
                check("req_wdata", bus.mmio_wdata, e.wdata);
            end
        end else begin
            check("idle_bus_zero",
                  {63'd0, (bus.mmio_addr != 0) || (bus.mmio_tid != 0) || (bus.mmio_wdata != 0)},
                  64'd0);
        end
        if (bus.rsp_valid) begin
            if (rsp_q.size() == 0) begin
                unexpected("rsp_valid");
            end else begin
                r = rsp_q[0];
                if (!rsp_prev) check("rsp_cycle", 64'(cyc), 64'(r.cyc));
                check("rsp_data", bus.rsp_data, r.data);
                check("rsp_timeout", {63'd0, bus.rsp_timeout}, {63'd0, r.to});
                if (bus.rsp_ready) void'(rsp_q.pop_front());
            end
        end
        rsp_prev = bus.rsp_valid;
        if (bus.stray_rsp) begin
            if (stray_q.size() == 0) unexpected("stray_rsp");
            else check("stray_cycle", 64'(cyc), 64'(stray_q.pop_front()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [15:0] addr, input logic [63:0] data);
        req_t e;
        int   n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_data  = data;
        while (!bus.cmd_ready && n < 50) begin
            step();
            n++;
        end
        if (n == 50) unexpected("cmd_ready_wait");
        e.rd    = !wr;
        e.addr  = {addr[15:1], 1'b0};
        e.tid   = tid_model;
        e.wdata = wr ? data : 64'd0;
        e.cyc   = cyc + 1;
        req_q.push_back(e);
        tid_model = tid_model + 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_data  = '0;
    endtask

    task automatic send_c2(input logic [TW-1:0] tid, input logic [63:0] data, input logic stray);
        rsp_t r;
        bus.c2_rsp_valid = 1'b1;
        bus.c2_rsp_tid   = tid;
        bus.c2_rsp_data  = data;
        if (stray) begin
            stray_q.push_back(cyc + 1);
        end else begin
            r.data = data;
            r.to   = 1'b0;
            r.cyc  = cyc + 1;
            rsp_q.push_back(r);
        end
        step();
        bus.c2_rsp_valid = 1'b0;
        bus.c2_rsp_tid   = '0;
        bus.c2_rsp_data  = '0;
    endtask

    task automatic finish_rsp(input int max_wait);
        int n = 0;
        bus.rsp_ready = 1'b1;
        while (!bus.rsp_valid && n < max_wait) begin
            step();
            n++;
        end
        if (n == max_wait) unexpected("rsp_wait_expired");
        step();
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   c0;
        rsp_t r;
        reset            = 1'b1;
        bus.cmd_valid    = 1'b0;
        bus.cmd_write    = 1'b0;
        bus.cmd_addr     = '0;
        bus.cmd_data     = '0;
        bus.c2_rsp_valid = 1'b0;
        bus.c2_rsp_tid   = '0;
        bus.c2_rsp_data  = '0;
        bus.rsp_ready    = 1'b0;
        repeat (3) step();
        reset = 1'b0;

        // Reset state.
        check("rst_cmd_ready", {63'd0, bus.cmd_ready}, 64'd1);
        check("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        check("rst_rsp_timeout", {63'd0, bus.rsp_timeout}, 64'd0);
        check("rst_rsp_data", bus.rsp_data, 64'd0);
        check("rst_stray", {63'd0, bus.stray_rsp}, 64'd0);
        check("rst_strobes", {62'd0, bus.mmio_rd_valid, bus.mmio_wr_valid}, 64'd0);
        step();

        // Back-to-back writes, tid 0 and 1.
        issue(1'b1, 16'h000C, 64'h1234);
        check("wr_cmd_ready_stays", {63'd0, bus.cmd_ready}, 64'd1);
        issue(1'b1, 16'h0010, 64'h5678);

        // Read tid 2, response five cycles later, held for 3 cycles.
        issue(1'b0, 16'h0004, 64'hDEAD);
        repeat (4) step();
        send_c2(9'd2, 64'ha0a013a421139e69, 1'b0);
        repeat (3) step();
        finish_rsp(10);
        check("post_hs_cmd_ready", {63'd0, bus.cmd_ready}, 64'd1);
        check("post_hs_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);

        // Writes tid 3,4 (odd address masked), read tid 5 with a stray tid 4 first.
        issue(1'b1, 16'h0021, 64'h0000_0000_CAFE_F00D);
        issue(1'b1, 16'hFFFF, 64'hFFFF_0000_FFFF_0000);
        issue(1'b0, 16'h0008, 64'h0);
        repeat (2) step();
        send_c2(9'd4, 64'h1111, 1'b1);
        repeat (2) step();
        check("stray_no_rsp", {63'd0, bus.rsp_valid}, 64'd0);
        send_c2(9'd5, 64'h0123_4567_89ab_cdef, 1'b0);
        finish_rsp(10);

        // Read tid 6 that never gets a timely answer.
        c0 = cyc;
        issue(1'b0, 16'h0030, 64'h0);
`ifdef VAI_MMIO_INIT_TIMEOUT_EN
        r.data = 64'hFFFF_FFFF_FFFF_FFFF;
        r.to   = 1'b1;
        r.cyc  = c0 + 1 + TO;
        rsp_q.push_back(r);
        finish_rsp(40);
        send_c2(9'd6, 64'h6666, 1'b1);
`else
        repeat (100) step();
        check("no_timeout_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        check("no_timeout_cmd_ready", {63'd0, bus.cmd_ready}, 64'd0);
        send_c2(9'd6, 64'h6666, 1'b0);
        finish_rsp(10);
`endif
        step();

        // Reset while a read (tid 7) is outstanding.
        issue(1'b0, 16'h0040, 64'h0);
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        tid_model = '0;
        check("rst_rdwait_cmd_ready", {63'd0, bus.cmd_ready}, 64'd1);
        check("rst_rdwait_strobes", {62'd0, bus.mmio_rd_valid, bus.mmio_wr_valid}, 64'd0);
        check("rst_rdwait_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        send_c2(9'd7, 64'h7777, 1'b1);
        repeat (2) step();

        // 513 consecutive writes: tids 0..511 then wrap to 0.
        for (int i = 0; i < 513; i++) begin
            issue(1'b1, 16'(i * 5 + 1), 64'(i) * 64'h0000_0001_0000_0001);
        end
        repeat (3) step();

        check("req_q_empty", 64'(req_q.size()), 64'd0);
        check("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
        check("stray_q_empty", 64'(stray_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
